// File: rtl/alu_rr_scheduler_pkg.sv
// Shared definitions for the round-robin ALU scheduler: ALU command codes,
// scheduler FSM states and datapath widths.
package alu_rr_scheduler_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CMD_W  = 4;
    localparam int unsigned RES_W  = 64;
    localparam int unsigned LAT_W  = 4;

    typedef enum logic [CMD_W-1:0] {
        CMD_ADD  = 4'd0,
        CMD_INC  = 4'd1,
        CMD_SUB  = 4'd2,
        CMD_DEC  = 4'd3,
        CMD_MUL  = 4'd4,
        CMD_DIV  = 4'd5,
        CMD_SHL  = 4'd6,
        CMD_SHR  = 4'd7,
        CMD_AND  = 4'd8,
        CMD_OR   = 4'd9,
        CMD_INV  = 4'd10,
        CMD_NAND = 4'd11,
        CMD_NOR  = 4'd12,
        CMD_XOR  = 4'd13,
        CMD_XNOR = 4'd14,
        CMD_BUF  = 4'd15
    } alu_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } sched_state_e;

endpackage

// File: rtl/alu_rr_scheduler_arb.sv
// Combinational round-robin arbiter: the first asserted request searching
// upward from last_grant+1 (mod NREQ) wins; grant is one-hot plus its index.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_last_grant,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_grant_idx
);

    always_comb begin : arb
        int unsigned idx;
        logic        found;
        o_grant     = '0;
        o_grant_idx = '0;
        found       = 1'b0;
        idx         = 0;
        // Offset NREQ wraps back to last_grant itself, so it is considered last.
        for (int unsigned off = 1; off <= NREQ; off++) begin
            idx = (int'(i_last_grant) + off) % NREQ;
            if (!found && i_req[idx]) begin
                found        = 1'b1;
                o_grant[idx] = 1'b1;
                o_grant_idx  = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one external 32-bit ALU between NREQ requesters with round-robin
// arbitration; returns the registered 64-bit result tagged with the requester ID.
module alu_rr_scheduler
    import alu_rr_scheduler_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned IDW     = 2,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DATA_W-1:0] req_a,
    input  logic [NREQ*DATA_W-1:0] req_b,
    input  logic [NREQ*CMD_W-1:0]  req_cmd,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [RES_W-1:0]       rsp_data,
    output logic                   busy,
    output logic [DATA_W-1:0]      alu_a,
    output logic [DATA_W-1:0]      alu_b,
    output logic [CMD_W-1:0]       alu_cmd,
    output logic                   alu_oe,
    input  logic [RES_W-1:0]       alu_d
);

    sched_state_e      r_state;
    sched_state_e      w_state_nxt;
    logic [IDW-1:0]    r_last_grant;
    logic [IDW-1:0]    r_id;
    logic [LAT_W-1:0]  r_lat_cnt;
    logic              r_rsp_valid;
    logic [IDW-1:0]    r_rsp_id;
    logic [RES_W-1:0]  r_rsp_data;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [CMD_W-1:0]  r_alu_cmd;
    logic              r_alu_oe;

    logic [NREQ-1:0]   w_grant;
    logic [IDW-1:0]    w_grant_idx;
    logic              w_xfer;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .i_req        (req_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_grant_idx  (w_grant_idx)
    );

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        if (r_state == ST_IDLE && !rst) begin
            req_ready = w_grant;
        end
        w_xfer = |(req_valid & req_ready);
        case (r_state)
            ST_IDLE: if (w_xfer) w_state_nxt = ST_EXEC;
            ST_EXEC: if (r_lat_cnt == '0) w_state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= IDW'(NREQ - 1);
            r_id         <= '0;
            r_lat_cnt    <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_data   <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_cmd    <= '0;
            r_alu_oe     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer) begin
                        r_alu_a      <= req_a[int'(w_grant_idx)*DATA_W +: DATA_W];
                        r_alu_b      <= req_b[int'(w_grant_idx)*DATA_W +: DATA_W];
                        r_alu_cmd    <= req_cmd[int'(w_grant_idx)*CMD_W +: CMD_W];
                        r_id         <= w_grant_idx;
                        r_last_grant <= w_grant_idx;
                        r_lat_cnt    <= LAT_W'(ALU_LAT - 1);
                        r_alu_oe     <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    // Capture on the last enabled cycle; oe drops on the same edge.
                    if (r_lat_cnt == '0) begin
                        r_rsp_data  <= alu_d;
                        r_rsp_id    <= r_id;
                        r_rsp_valid <= 1'b1;
                        r_alu_oe    <= 1'b0;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) r_rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign busy      = (r_state != ST_IDLE);
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_cmd   = r_alu_cmd;
    assign alu_oe    = r_alu_oe;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler: two instances (ALU_LAT=1 and 3), each
// wired to a behavioural ALU that drives a poison pattern while oe is low.
module tb_alu_rr_scheduler;
    import alu_rr_scheduler_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [63:0] POISON = 64'hBAD0_BAD0_BAD0_BAD0;

    // ---- instance with ALU_LAT=1 ----
    logic         rst1;
    logic [3:0]   req_valid1, req_ready1;
    logic [127:0] req_a1, req_b1;
    logic [15:0]  req_cmd1;
    logic         rsp_valid1, rsp_ready1, busy1, alu_oe1;
    logic [1:0]   rsp_id1;
    logic [63:0]  rsp_data1, alu_d1;
    logic [31:0]  alu_a1, alu_b1;
    logic [3:0]   alu_cmd1;

    // ---- instance with ALU_LAT=3 ----
    logic         rst3;
    logic [3:0]   req_valid3, req_ready3;
    logic [127:0] req_a3, req_b3;
    logic [15:0]  req_cmd3;
    logic         rsp_valid3, rsp_ready3, busy3, alu_oe3;
    logic [1:0]   rsp_id3;
    logic [63:0]  rsp_data3, alu_d3;
    logic [31:0]  alu_a3, alu_b3;
    logic [3:0]   alu_cmd3;

    function automatic logic [63:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] cmd);
        logic [63:0] ea, eb;
        ea = {32'd0, a};
        eb = {32'd0, b};
        case (cmd)
            CMD_ADD:  return ea + eb;
            CMD_INC:  return ea + 64'd1;
            CMD_SUB:  return ea - eb;
            CMD_DEC:  return ea - 64'd1;
            CMD_MUL:  return ea * eb;
            CMD_DIV:  return (b == 32'd0) ? 64'd0 : ea / eb;
            CMD_SHL:  return ea << 1;
            CMD_SHR:  return ea >> 1;
            CMD_AND:  return ea & eb;
            CMD_OR:   return ea | eb;
            CMD_INV:  return {32'd0, ~a};
            CMD_NAND: return {32'd0, ~(a & b)};
            CMD_NOR:  return {32'd0, ~(a | b)};
            CMD_XOR:  return ea ^ eb;
            CMD_XNOR: return {32'd0, ~(a ^ b)};
            default:  return ea;
        endcase
    endfunction

    assign alu_d1 = alu_oe1 ? alu_model(alu_a1, alu_b1, alu_cmd1) : POISON;
    assign alu_d3 = alu_oe3 ? alu_model(alu_a3, alu_b3, alu_cmd3) : POISON;

    alu_rr_scheduler #(.NREQ(4), .IDW(2), .ALU_LAT(1)) dut1 (
        .clk(clk), .rst(rst1), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_a(req_a1), .req_b(req_b1), .req_cmd(req_cmd1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_id(rsp_id1),
        .rsp_data(rsp_data1), .busy(busy1), .alu_a(alu_a1), .alu_b(alu_b1),
        .alu_cmd(alu_cmd1), .alu_oe(alu_oe1), .alu_d(alu_d1)
    );

    alu_rr_scheduler #(.NREQ(4), .IDW(2), .ALU_LAT(3)) dut3 (
        .clk(clk), .rst(rst3), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_a(req_a3), .req_b(req_b3), .req_cmd(req_cmd3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_id(rsp_id3),
        .rsp_data(rsp_data3), .busy(busy3), .alu_a(alu_a3), .alu_b(alu_b3),
        .alu_cmd(alu_cmd3), .alu_oe(alu_oe3), .alu_d(alu_d3)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set1(input int id, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] cmd);
        req_a1[id*32 +: 32] = a;
        req_b1[id*32 +: 32] = b;
        req_cmd1[id*4 +: 4] = cmd;
    endtask

    task automatic set3(input int id, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] cmd);
        req_a3[id*32 +: 32] = a;
        req_b3[id*32 +: 32] = b;
        req_cmd3[id*4 +: 4] = cmd;
    endtask

    task automatic reset1();
        rst1       = 1'b1;
        req_valid1 = '0;
        tick();
        tick();
        rst1 = 1'b0;
    endtask

    // One isolated transaction on the ALU_LAT=1 instance with rsp_ready high.
    task automatic run_one(input string tag, input int id, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] cmd, input logic [63:0] exp);
        int n, oe_cnt;
        set1(id, a, b, cmd);
        req_valid1 = 4'(1 << id);
        rsp_ready1 = 1'b1;
        #1;
        check_eq({tag, "_ready"}, 64'(req_ready1), 64'(1 << id));
        tick();
        req_valid1 = '0;
        n = 1;
        oe_cnt = 0;
        while (!rsp_valid1 && n < 20) begin
            if (alu_oe1) oe_cnt++;
            tick();
            n++;
        end
        check_eq({tag, "_lat"}, 64'(n), 64'd2);
        check_eq({tag, "_oe_cycles"}, 64'(oe_cnt), 64'd1);
        check_eq({tag, "_oe_off"}, 64'(alu_oe1), 64'd0);
        check_eq({tag, "_data"}, rsp_data1, exp);
        check_eq({tag, "_id"}, 64'(rsp_id1), 64'(id));
        tick();
        check_eq({tag, "_idle"}, 64'(busy1), 64'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n, nresp, seen, oe_cnt;
        rst1 = 1'b1; rst3 = 1'b1;
        req_valid1 = '0; req_valid3 = '0;
        req_a1 = '0; req_b1 = '0; req_cmd1 = '0;
        req_a3 = '0; req_b3 = '0; req_cmd3 = '0;
        rsp_ready1 = 1'b1; rsp_ready3 = 1'b1;
        repeat (2) tick();

        // Reset values; requests are ignored while rst is high.
        req_valid1 = 4'hF;
        #1;
        check_eq("rst_ready", 64'(req_ready1), 64'd0);
        tick();
        check_eq("rst_busy", 64'(busy1), 64'd0);
        check_eq("rst_rsp_valid", 64'(rsp_valid1), 64'd0);
        check_eq("rst_rsp_id", 64'(rsp_id1), 64'd0);
        check_eq("rst_rsp_data", rsp_data1, 64'd0);
        check_eq("rst_alu_oe", 64'(alu_oe1), 64'd0);
        check_eq("rst_alu_a", 64'(alu_a1), 64'd0);
        check_eq("rst_alu_b", 64'(alu_b1), 64'd0);
        check_eq("rst_alu_cmd", 64'(alu_cmd1), 64'd0);
        req_valid1 = '0;
        rst1 = 1'b0;
        rst3 = 1'b0;
        tick();

        run_one("add", 0, 32'd25, 32'd17, CMD_ADD, 64'd42);
        run_one("mul", 2, 32'hFFFF_FFFF, 32'd2, CMD_MUL, 64'h1_FFFF_FFFE);

        // Fairness: all requesters valid continuously.
        reset1();
        for (int i = 0; i < 4; i++) set1(i, 32'(i), 32'(i + 1), CMD_SUB);
        req_valid1 = 4'hF;
        rsp_ready1 = 1'b1;
        nresp = 0;
        n = 0;
        while (nresp < 6 && n < 100) begin
            tick();
            n++;
            if (rsp_valid1) begin
                check_eq($sformatf("fair_id%0d", nresp), 64'(rsp_id1), 64'(nresp % 4));
                check_eq($sformatf("fair_data%0d", nresp), rsp_data1, 64'hFFFF_FFFF_FFFF_FFFF);
                nresp++;
            end
        end
        check_eq("fair_count", 64'(nresp), 64'd6);
        reset1();

        // Backpressure: response held 5 cycles while requester 1 waits.
        set1(0, 32'd7, 32'd6, CMD_MUL);
        set1(1, 32'd100, 32'd1, CMD_SUB);
        rsp_ready1 = 1'b0;
        req_valid1 = 4'b0001;
        #1;
        check_eq("bp_ready0", 64'(req_ready1), 64'd1);
        tick();
        req_valid1 = 4'b0010;
        n = 0;
        while (!rsp_valid1 && n < 20) begin
            tick();
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            check_eq($sformatf("bp_valid%0d", k), 64'(rsp_valid1), 64'd1);
            check_eq($sformatf("bp_data%0d", k), rsp_data1, 64'd42);
            check_eq($sformatf("bp_id%0d", k), 64'(rsp_id1), 64'd0);
            check_eq($sformatf("bp_noready%0d", k), 64'(req_ready1), 64'd0);
            check_eq($sformatf("bp_busy%0d", k), 64'(busy1), 64'd1);
            tick();
        end
        rsp_ready1 = 1'b1;
        #1;
        check_eq("bp_hs_noready", 64'(req_ready1), 64'd0);
        tick();
        check_eq("bp_after_valid", 64'(rsp_valid1), 64'd0);
        check_eq("bp_grant1", 64'(req_ready1), 64'b0010);
        tick();
        req_valid1 = '0;
        check_eq("bp_alu_a1", 64'(alu_a1), 64'd100);
        n = 0;
        while (!rsp_valid1 && n < 20) begin
            tick();
            n++;
        end
        check_eq("bp_r1_id", 64'(rsp_id1), 64'd1);
        check_eq("bp_r1_data", rsp_data1, 64'd99);
        tick();

        // ALU_LAT=3: DIV 20/10.
        set3(0, 32'd20, 32'd10, CMD_DIV);
        req_valid3 = 4'b0001;
        #1;
        check_eq("lat3_ready", 64'(req_ready3), 64'd1);
        tick();
        req_valid3 = '0;
        n = 1;
        oe_cnt = 0;
        while (!rsp_valid3 && n < 30) begin
            if (alu_oe3) oe_cnt++;
            tick();
            n++;
        end
        check_eq("lat3_edges", 64'(n), 64'd4);
        check_eq("lat3_oe_cycles", 64'(oe_cnt), 64'd3);
        check_eq("lat3_data", rsp_data3, 64'd2);
        check_eq("lat3_id", 64'(rsp_id3), 64'd0);
        tick();

        // Reset during the second EXEC cycle discards the operation.
        set3(3, 32'd5, 32'd5, CMD_ADD);
        req_valid3 = 4'b1000;
        #1;
        check_eq("rmid_ready3", 64'(req_ready3), 64'b1000);
        tick();
        req_valid3 = '0;
        check_eq("rmid_oe_exec1", 64'(alu_oe3), 64'd1);
        tick();
        check_eq("rmid_busy_exec2", 64'(busy3), 64'd1);
        rst3 = 1'b1;
        tick();
        check_eq("rmid_oe", 64'(alu_oe3), 64'd0);
        check_eq("rmid_rsp_valid", 64'(rsp_valid3), 64'd0);
        check_eq("rmid_busy", 64'(busy3), 64'd0);
        rst3 = 1'b0;
        seen = 0;
        repeat (8) begin
            tick();
            if (rsp_valid3) seen++;
        end
        check_eq("rmid_no_rsp", 64'(seen), 64'd0);
        req_valid3 = 4'b1001;
        #1;
        check_eq("rmid_grant0", 64'(req_ready3), 64'b0001);
        tick();
        req_valid3 = '0;
        n = 0;
        while (!rsp_valid3 && n < 30) begin
            tick();
            n++;
        end
        check_eq("rmid_next_id", 64'(rsp_id3), 64'd0);
        check_eq("rmid_next_data", rsp_data3, 64'd2);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
